// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer stream blocks: word width, FSM
// encoding and the per-layer input counts used by the dense tops.
package dense_pkg;

  localparam int DENSE_DATA_WIDTH = 16;

  localparam int DENSE1_NUM_INPUTS = 32;
  localparam int DENSE2_NUM_INPUTS = 64;
  localparam int DENSE_TB_NUM_INPUTS = 4;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/dense_frame_buf.sv
// Activation frame buffer: one synchronous write port, one combinational
// read port. Data is deliberately not reset.
module dense_frame_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [DATA_WIDTH-1:0] r_mem [NUM_INPUTS];
  logic [IW-1:0]         w_widx;
  logic [IW-1:0]         w_ridx;

  // Controller only ever addresses 0..NUM_INPUTS-1, so the low bits suffice.
  assign w_widx = i_waddr[IW-1:0];
  assign w_ridx = i_raddr[IW-1:0];

  // Word store
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[w_ridx];

endmodule

// File: rtl/dense_frame_tx.sv
// Dense-layer transmit end: fills one activation vector, then replays it as a
// framed one-word-per-cycle stream with registered qualifiers.
module dense_frame_tx
  import dense_pkg::*;
#(
  parameter int DATA_WIDTH = DENSE_DATA_WIDTH,
  parameter int NUM_INPUTS = DENSE1_NUM_INPUTS,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  flush,
  output logic                  full,
  output logic                  busy,
  output logic                  ena_out,
  output logic                  frame_start_out,
  output logic                  frame_end_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  err_overflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_INPUTS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic [CW-1:0]         w_wr_cnt_nxt;
  logic [CW-1:0]         w_rd_cnt_nxt;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  logic                  r_full;
  logic                  r_busy;
  logic                  r_ena;
  logic                  r_fs;
  logic                  r_fe;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_err;

  logic                  w_full_nxt;
  logic                  w_busy_nxt;
  logic                  w_ena_nxt;
  logic                  w_fs_nxt;
  logic                  w_fe_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;

  dense_frame_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_INPUTS(NUM_INPUTS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .i_clk  (clk),
    .i_we   (w_mem_we),
    .i_waddr(w_mem_waddr),
    .i_wdata(wr_data),
    .i_raddr(r_rd_cnt[ADDR_WIDTH-1:0]),
    .o_rdata(w_mem_rdata)
  );

  // FSM state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FILL;
      r_wr_cnt <= {CW{1'b0}};
      r_rd_cnt <= {CW{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
    end
  end

  // Next-state decode; flush beats start beats wr_en
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (wr_en && (r_wr_cnt == LAST_IDX)) begin
            w_state_nxt = ST_READY;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
        ST_READY: begin
          if (start) begin
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_READY;
          end
        end
        ST_SEND: begin
          if (r_rd_cnt == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
        ST_DONE:  w_state_nxt = ST_FILL;
        default:  w_state_nxt = ST_FILL;
      endcase
    end
  end

  // Counters and buffer write; a write in DONE lands as word 0 of the next frame
  always_comb begin
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    w_mem_we     = 1'b0;
    w_mem_waddr  = r_wr_cnt[ADDR_WIDTH-1:0];
    if (flush) begin
      w_wr_cnt_nxt = {CW{1'b0}};
      w_rd_cnt_nxt = {CW{1'b0}};
    end else begin
      case (r_state)
        ST_FILL: begin
          if (wr_en) begin
            w_mem_we     = 1'b1;
            w_wr_cnt_nxt = r_wr_cnt + CNT_ONE;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt;
          end
        end
        ST_READY: begin
          if (start) begin
            w_rd_cnt_nxt = {CW{1'b0}};
          end else begin
            w_rd_cnt_nxt = r_rd_cnt;
          end
        end
        ST_SEND: begin
          w_rd_cnt_nxt = r_rd_cnt + CNT_ONE;
        end
        ST_DONE: begin
          w_rd_cnt_nxt = {CW{1'b0}};
          if (wr_en) begin
            w_mem_we     = 1'b1;
            w_mem_waddr  = {ADDR_WIDTH{1'b0}};
            w_wr_cnt_nxt = CNT_ONE;
          end else begin
            w_wr_cnt_nxt = {CW{1'b0}};
          end
        end
        default: begin
          w_wr_cnt_nxt = {CW{1'b0}};
          w_rd_cnt_nxt = {CW{1'b0}};
        end
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    w_full_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    w_ena_nxt  = 1'b0;
    w_fs_nxt   = 1'b0;
    w_fe_nxt   = 1'b0;
    w_data_nxt = {DATA_WIDTH{1'b0}};
    w_done_nxt = 1'b0;
    w_err_nxt  = r_err;
    if (flush) begin
      w_err_nxt = 1'b0;
    end else begin
      w_full_nxt = (w_state_nxt != ST_FILL);
      w_busy_nxt = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_DONE);
      case (r_state)
        ST_FILL: begin
          w_err_nxt = r_err;
        end
        ST_READY: begin
          if (wr_en) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end
        ST_SEND: begin
          w_ena_nxt  = 1'b1;
          w_fs_nxt   = (r_rd_cnt == {CW{1'b0}});
          w_fe_nxt   = (r_rd_cnt == LAST_IDX);
          w_data_nxt = w_mem_rdata;
          if (wr_en) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end
        ST_DONE: begin
          w_done_nxt = 1'b1;
        end
        default: begin
          w_err_nxt = r_err;
        end
      endcase
    end
  end

  // Output registers; async reset clears every output at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_busy <= 1'b0;
      r_ena  <= 1'b0;
      r_fs   <= 1'b0;
      r_fe   <= 1'b0;
      r_data <= {DATA_WIDTH{1'b0}};
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_busy <= w_busy_nxt;
      r_ena  <= w_ena_nxt;
      r_fs   <= w_fs_nxt;
      r_fe   <= w_fe_nxt;
      r_data <= w_data_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign full            = r_full;
  assign busy            = r_busy;
  assign ena_out         = r_ena;
  assign frame_start_out = r_fs;
  assign frame_end_out   = r_fe;
  assign data_out        = r_data;
  assign done            = r_done;
  assign err_overflow    = r_err;

endmodule

// File: tb/tb_dense_frame_tx.sv
// Directed bench for dense_frame_tx with NUM_INPUTS=4: a vector table for
// fill/stream/overflow plus hand sequences for flush, back-to-back and reset.
module tb_dense_frame_tx;
  import dense_pkg::*;

  localparam int DW = 16;
  localparam int NI = DENSE_TB_NUM_INPUTS;
  localparam int NV = 24;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          flush;
  logic          full;
  logic          busy;
  logic          ena_out;
  logic          frame_start_out;
  logic          frame_end_out;
  logic [DW-1:0] data_out;
  logic          done;
  logic          err_overflow;

  int checks;
  int failures;

  typedef struct {
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          full;
    logic          busy;
    logic          ena;
    logic          fs;
    logic          fe;
    logic [DW-1:0] data;
    logic          done;
    logic          err;
  } vec_t;

  vec_t vecs [NV];

  dense_frame_tx #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(NI),
    .ADDR_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .start          (start),
    .flush          (flush),
    .full           (full),
    .busy           (busy),
    .ena_out        (ena_out),
    .frame_start_out(frame_start_out),
    .frame_end_out  (frame_end_out),
    .data_out       (data_out),
    .done           (done),
    .err_overflow   (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic [DW-1:0] d, input logic s,
                              input logic f, input logic b, input logic e,
                              input logic fs, input logic fe, input logic [DW-1:0] q,
                              input logic dn, input logic er);
    vec_t v;
    v.wr_en = w; v.wr_data = d; v.start = s;
    v.full = f; v.busy = b; v.ena = e; v.fs = fs; v.fe = fe;
    v.data = q; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic f, input logic b, input logic e,
                            input logic fs, input logic fe, input logic [DW-1:0] q,
                            input logic dn, input logic er);
    chk({tag, ".full"}, {15'd0, full}, {15'd0, f});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
    chk({tag, ".ena"}, {15'd0, ena_out}, {15'd0, e});
    chk({tag, ".fs"}, {15'd0, frame_start_out}, {15'd0, fs});
    chk({tag, ".fe"}, {15'd0, frame_end_out}, {15'd0, fe});
    chk({tag, ".data"}, data_out, q);
    chk({tag, ".done"}, {15'd0, done}, {15'd0, dn});
    chk({tag, ".err"}, {15'd0, err_overflow}, {15'd0, er});
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Issue start from READY and check the whole frame through the done pulse.
  task automatic run_frame(input string tag, input logic [DW-1:0] w [NI], input logic er);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out({tag, ".go"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, er);
    for (int i = 0; i < NI; i++) begin
      tick();
      expect_out($sformatf("%s.w%0d", tag, i), 1'b1, 1'b1, 1'b1, (i == 0), (i == NI - 1),
                 w[i], 1'b0, er);
    end
    tick();
    expect_out({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, er);
  endtask

  logic [DW-1:0] fb [NI];
  logic [DW-1:0] fc [NI];
  logic [DW-1:0] fd [NI];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 16'h0000;
    start    = 1'b0;
    flush    = 1'b0;

    //             wr    data     st    full  busy  ena   fs    fe    data     done  err
    vecs[0]  = mk(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1);
    vecs[19] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b1);
    vecs[20] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1);
    vecs[21] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1);
    vecs[22] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[23] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    fb[0] = 16'hB001; fb[1] = 16'hB002; fb[2] = 16'hB003; fb[3] = 16'hB004;
    fc[0] = 16'hC0DE; fc[1] = 16'h0001; fc[2] = 16'hFFFF; fc[3] = 16'h8001;
    fd[0] = 16'h1234; fd[1] = 16'h5678; fd[2] = 16'h9ABC; fd[3] = 16'hDEF0;

    #12;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame, early start, overflow
    for (int i = 0; i < NV; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      start   = vecs[i].start;
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].full, vecs[i].busy, vecs[i].ena,
                 vecs[i].fs, vecs[i].fe, vecs[i].data, vecs[i].done, vecs[i].err);
    end
    wr_en = 1'b0;
    start = 1'b0;

    // Flush on the second stream cycle
    wr(16'hA001); wr(16'hA002); wr(16'hA003); wr(16'hA004);
    expect_out("fl.full", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    expect_out("fl.w0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA001, 1'b0, 1'b1);
    tick();
    expect_out("fl.w1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA002, 1'b0, 1'b1);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 16'hEEEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    expect_out("fl.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("fl.idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    for (int i = 0; i < NI; i++) wr(fb[i]);
    expect_out("fl.refill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_frame("fB", fb, 1'b0);

    // Back-to-back: first word of the next frame written in the done cycle
    wr(fc[0]);
    expect_out("b2b.w0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    wr(fc[1]);
    wr(fc[2]);
    expect_out("b2b.w2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    wr(fc[3]);
    expect_out("b2b.full", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_frame("fC", fc, 1'b0);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < NI; i++) wr(fd[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    expect_out("rst.pre", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, fd[1], 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    expect_out("rst.nostart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) wr(fd[i]);
    expect_out("rst.refill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_frame("fD", fd, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
